// File: rtl/systolic_4_pkg.sv
// rtl/systolic_4_pkg.sv - shared constants and FSM encoding for the 2x2 systolic MAC array
package systolic_4_pkg;

  localparam int SYS_DW = 16;

  // Input buffer select codes on ibus address bits [15:10]: A0, A1, B0, B1
  localparam logic [3:0][5:0] IN_SEL = {6'h03, 6'h02, 6'h01, 6'h00};

  // Output buffer select codes on ibus address bits [15:9]: S0_0, S1_0, S0_1, S1_1
  localparam logic [3:0][6:0] OUT_SEL = {7'h43, 7'h42, 7'h41, 7'h40};

  // Control register word addresses
  localparam logic [13:0] REG_START = 14'h3FF8;
  localparam logic [13:0] REG_MAX   = 14'h3FF9;
  localparam logic [13:0] REG_RUN   = 14'h3FFA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/systolic_4_sys_buf_ram.sv
// rtl/systolic_4_sys_buf_ram.sv - simple dual-port synchronous RAM, one write port and one registered read port
module sys_buf_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Plain storage: contents are not reset so they can be preloaded
  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdata;
    if (re) rdata <= mem[radr];
  end

endmodule

// File: rtl/systolic_4.sv
// rtl/systolic_4.sv - 2x2 systolic multiply-accumulate array with buffer RAMs and DMA IO registers
module systolic_4
  import systolic_4_pkg::*;
#(
  parameter int ABUF_AW = 10,
  parameter int OBUF_AW = 9,
  parameter int DW      = SYS_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dma_io_we,
  input  logic [15:2]   dma_io_wadr,
  input  logic [15:0]   dma_io_wdata,
  input  logic [15:2]   dma_io_radr,
  input  logic [15:0]   dma_io_rdata_in,
  output logic [15:0]   dma_io_rdata,
  input  logic          ibus_ren,
  input  logic [15:0]   ibus_radr,
  output logic [15:0]   ibus_rdata,
  input  logic          ibus_wen,
  input  logic [15:0]   ibus_wadr,
  input  logic [15:0]   ibus_wdata
);

  state_t state, state_nxt;
  logic   busy;
  logic   start_req;
  logic   fill_done;

  logic [15:0] max_reg, run_reg;
  logic [15:0] max_l, run_l;
  logic [15:0] k_cnt, r_cnt;
  logic [ABUF_AW-1:0] s_adr;
  logic [1:0]  drain_cnt;

  logic [3:0] in_wsel, in_rsel, out_wsel, out_rsel;
  logic [3:0][DW-1:0] in_rd, out_rd;

  logic       rsel_v, rsel_out;
  logic [1:0] rsel_idx;

  // Stream control pipeline: stage n lines up with data n cycles after the address issue
  logic [3:1]              pv, pf, pl;
  logic [3:1][OBUF_AW-1:0] pr;

  // Skew and hop registers between PEs
  logic [DW-1:0] a0_h, a1_s, a1_h, b0_v, b1_s, b1_v;

  logic [3:0][DW-1:0]      pe_a, pe_b;
  logic [3:0]              pe_v, pe_f, pe_l;
  logic [3:0][OBUF_AW-1:0] pe_r;

  assign busy      = (state != ST_IDLE);
  assign start_req = dma_io_we && (dma_io_wadr == REG_START) && dma_io_wdata[0];
  assign fill_done = (state == ST_FILL) && (k_cnt == max_l) && (r_cnt == run_l);

  // Buffer address decode for both ibus ports
  always_comb begin
    in_wsel  = '0;
    in_rsel  = '0;
    out_wsel = '0;
    out_rsel = '0;
    for (int b = 0; b < 4; b++) begin
      in_wsel[b]  = ibus_wen && (ibus_wadr[15:10] == IN_SEL[b]);
      out_wsel[b] = ibus_wen && (ibus_wadr[15:9] == OUT_SEL[b]);
      in_rsel[b]  = (ibus_radr[15:10] == IN_SEL[b]);
      out_rsel[b] = (ibus_radr[15:9] == OUT_SEL[b]);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a start while busy is simply not looked at
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_req) state_nxt = ST_FILL;
      ST_FILL:  if (fill_done) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'd3) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control registers; a run works on copies latched at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_reg <= '0;
      run_reg <= '0;
    end else if (dma_io_we) begin
      if (dma_io_wadr == REG_MAX) max_reg <= dma_io_wdata;
      if (dma_io_wadr == REG_RUN) run_reg <= dma_io_wdata;
    end
  end

  // Run counters: element index within the vector, result index, and streaming address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_l     <= '0;
      run_l     <= '0;
      k_cnt     <= '0;
      r_cnt     <= '0;
      s_adr     <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == ST_IDLE && start_req) begin
        max_l <= max_reg;
        run_l <= run_reg;
        k_cnt <= '0;
        r_cnt <= '0;
        s_adr <= '0;
      end else if (state == ST_FILL) begin
        s_adr <= s_adr + 1'b1;
        if (k_cnt == max_l) begin
          k_cnt <= '0;
          r_cnt <= r_cnt + 16'd1;
        end else begin
          k_cnt <= k_cnt + 16'd1;
        end
      end
    end
  end

  // Delay vector markers alongside the data as it moves through the grid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      pf <= '0;
      pl <= '0;
      pr <= '0;
    end else begin
      pv <= {pv[2:1], (state == ST_FILL)};
      pf <= {pf[2:1], (k_cnt == 16'd0)};
      pl <= {pl[2:1], (k_cnt == max_l)};
      pr <= {pr[2:1], r_cnt[OBUF_AW-1:0]};
    end
  end

  // Row 1 / column 1 skew and the right/down hops between PEs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_h <= '0;
      a1_s <= '0;
      a1_h <= '0;
      b0_v <= '0;
      b1_s <= '0;
      b1_v <= '0;
    end else begin
      a0_h <= in_rd[0];
      a1_s <= in_rd[1];
      a1_h <= a1_s;
      b0_v <= in_rd[2];
      b1_s <= in_rd[3];
      b1_v <= b1_s;
    end
  end

  // PE operand routing; PE index p equals its output buffer index (S0_0, S1_0, S0_1, S1_1)
  always_comb begin
    pe_a = {a1_h, a0_h, a1_s, in_rd[0]};
    pe_b = {b1_v, b1_s, b0_v, in_rd[2]};
    pe_v = {pv[3], pv[2], pv[2], pv[1]};
    pe_f = {pf[3], pf[2], pf[2], pf[1]};
    pe_l = {pl[3], pl[2], pl[2], pl[1]};
    pe_r = {pr[3], pr[2], pr[2], pr[1]};
  end

  for (genvar b = 0; b < 4; b++) begin : g_in
    sys_buf_ram #(.AW(ABUF_AW), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (in_wsel[b]),
      .wadr  (ibus_wadr[ABUF_AW-1:0]),
      .wdata (ibus_wdata),
      .re    (busy | (ibus_ren & in_rsel[b])),
      .radr  (busy ? s_adr : ibus_radr[ABUF_AW-1:0]),
      .rdata (in_rd[b])
    );
  end

  for (genvar p = 0; p < 4; p++) begin : g_pe
    logic [DW-1:0]      acc;
    logic               wb_en;
    logic [OBUF_AW-1:0] wb_adr;

    // Accumulate; first element restarts the sum, result is written the cycle after the last
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc    <= '0;
        wb_en  <= 1'b0;
        wb_adr <= '0;
      end else begin
        if (pe_v[p]) acc <= pe_f[p] ? pe_a[p] * pe_b[p] : acc + pe_a[p] * pe_b[p];
        wb_en  <= pe_v[p] & pe_l[p];
        wb_adr <= pe_r[p];
      end
    end

    sys_buf_ram #(.AW(OBUF_AW), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (wb_en | out_wsel[p]),
      .wadr  (wb_en ? wb_adr : ibus_wadr[OBUF_AW-1:0]),
      .wdata (wb_en ? acc : ibus_wdata),
      .re    (ibus_ren & out_rsel[p]),
      .radr  (ibus_radr[OBUF_AW-1:0]),
      .rdata (out_rd[p])
    );
  end

  // Remember which buffer the ibus read addressed so its data can be steered next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsel_v   <= 1'b0;
      rsel_out <= 1'b0;
      rsel_idx <= '0;
    end else begin
      rsel_v   <= ibus_ren && ((|in_rsel) || (|out_rsel));
      rsel_out <= |out_rsel;
      rsel_idx <= (|out_rsel) ? ibus_radr[10:9] : ibus_radr[11:10];
    end
  end

  // ibus read data: zero unless a mapped read was issued last cycle
  always_comb begin
    ibus_rdata = '0;
    if (rsel_v) ibus_rdata = rsel_out ? out_rd[rsel_idx] : in_rd[rsel_idx];
  end

  // Register read joins the daisy chain, passing upstream data when not addressed
  always_comb begin
    dma_io_rdata = dma_io_rdata_in;
    case (dma_io_radr)
      REG_START: dma_io_rdata = {15'b0, busy};
      REG_MAX:   dma_io_rdata = max_reg;
      REG_RUN:   dma_io_rdata = run_reg;
      default:   dma_io_rdata = dma_io_rdata_in;
    endcase
  end

endmodule

// File: tb/tb_systolic_4.sv
// tb/tb_systolic_4.sv - self-checking bench for systolic_4 against an array-level reference model
module tb_systolic_4;

  localparam logic [13:0] A_START = 14'h3FF8;
  localparam logic [13:0] A_MAX   = 14'h3FF9;
  localparam logic [13:0] A_RUN   = 14'h3FFA;

  logic        clk;
  logic        rst_n;
  logic        dma_io_we;
  logic [15:2] dma_io_wadr;
  logic [15:0] dma_io_wdata;
  logic [15:2] dma_io_radr;
  logic [15:0] dma_io_rdata_in;
  logic [15:0] dma_io_rdata;
  logic        ibus_ren;
  logic [15:0] ibus_radr;
  logic [15:0] ibus_rdata;
  logic        ibus_wen;
  logic [15:0] ibus_wadr;
  logic [15:0] ibus_wdata;

  int checks;
  int errors;
  int cyc_ctr;

  logic [15:0] m_in  [4][1024];
  logic [15:0] m_out [4][512];

  systolic_4 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dma_io_we       (dma_io_we),
    .dma_io_wadr     (dma_io_wadr),
    .dma_io_wdata    (dma_io_wdata),
    .dma_io_radr     (dma_io_radr),
    .dma_io_rdata_in (dma_io_rdata_in),
    .dma_io_rdata    (dma_io_rdata),
    .ibus_ren        (ibus_ren),
    .ibus_radr       (ibus_radr),
    .ibus_rdata      (ibus_rdata),
    .ibus_wen        (ibus_wen),
    .ibus_wadr       (ibus_wadr),
    .ibus_wdata      (ibus_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr = cyc_ctr + 1;

  function automatic logic [15:0] in_adr(int b, int idx);
    return 16'(b * 1024 + idx);
  endfunction

  function automatic logic [15:0] out_adr(int p, int idx);
    return 16'(32768 + p * 512 + idx);
  endfunction

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ibus_wen = 1'b1; ibus_wadr = a; ibus_wdata = d;
    @(posedge clk);
    #1 ibus_wen = 1'b0;
    if (a[15:12] == 4'h0) m_in[a[11:10]][a[9:0]] = d;
    else if (a[15:11] == 5'b10000) m_out[a[10:9]][a[8:0]] = d;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    ibus_ren = 1'b1; ibus_radr = a;
    @(negedge clk);
    d = ibus_rdata;
    ibus_ren = 1'b0;
  endtask

  task automatic reg_wr(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    dma_io_we = 1'b1; dma_io_wadr = a; dma_io_wdata = d;
    @(posedge clk);
    #1 dma_io_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [13:0] a, output logic [15:0] d);
    dma_io_radr = a;
    #1 d = dma_io_rdata;
  endtask

  task automatic start_run(output int t0);
    reg_wr(A_START, 16'hffff);
    t0 = cyc_ctr;
  endtask

  // Poll START until idle; returns cycles since the start edge, or -1 on timeout
  task automatic wait_idle(input int n, input int t0, output int dur);
    logic [15:0] d;
    dur = -1;
    for (int c = 0; c < n + 200; c++) begin
      @(negedge clk);
      reg_rd(A_START, d);
      if (d[0] == 1'b0) begin
        dur = cyc_ctr - t0;
        break;
      end
    end
  endtask

  // Reference: each result is the modular dot product of one L-long slice of Ai and Bj
  task automatic model_run(input int mx, input int rn);
    int L;
    logic [15:0] s;
    L = mx + 1;
    for (int r = 0; r <= rn; r++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          s = 16'h0;
          for (int k = 0; k < L; k++) begin
            int n;
            n = (r * L + k) % 1024;
            s = s + m_in[i][n] * m_in[2 + j][n];
          end
          m_out[i + 2 * j][r % 512] = s;
        end
  endtask

  task automatic fill_inputs(input int n);
    for (int b = 0; b < 4; b++)
      for (int idx = 0; idx < n; idx++)
        bus_wr(in_adr(b, idx), 16'($urandom));
  endtask

  task automatic prefill_out(input int n);
    for (int p = 0; p < 4; p++) begin
      for (int idx = 0; idx < n; idx++) bus_wr(out_adr(p, idx), 16'($urandom));
      bus_wr(out_adr(p, 256), 16'($urandom));
    end
  endtask

  task automatic test_reset;
    logic [15:0] d;
    reg_rd(A_START, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_start got %h exp 0000", d); end
    reg_rd(A_MAX, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_max got %h exp 0000", d); end
    reg_rd(A_RUN, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_run got %h exp 0000", d); end
    checks++; if (ibus_rdata !== 16'h0) begin errors++; $display("FAIL reset_ibus_rdata got %h exp 0000", ibus_rdata); end
  endtask

  task automatic test_ibus_rw;
    logic [15:0] a [16];
    logic [15:0] v [16];
    logic [15:0] d;
    int p, idx;
    for (int n = 0; n < 4; n++) begin
      a[n]      = in_adr(0, n);     v[n]      = 16'(n * 16'h1111);
      a[4 + n]  = in_adr(1, 4 + n); v[4 + n]  = 16'((4 + n) * 16'h1111);
      a[8 + n]  = in_adr(2, n);     v[8 + n]  = 16'((8 + n) * 16'h1111);
      a[12 + n] = in_adr(3, 4 + n); v[12 + n] = 16'((12 + n) * 16'h1111);
    end
    for (int n = 0; n < 16; n++) bus_wr(a[n], v[n]);
    for (int n = 0; n < 16; n++) begin
      bus_rd(a[n], d);
      checks++; if (d !== v[n]) begin errors++; $display("FAIL ibus_rd adr %h got %h exp %h", a[n], d, v[n]); end
    end
    for (int n = 0; n < 8; n++) begin
      p = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 511));
      bus_wr(out_adr(p, idx), 16'($urandom));
      bus_rd(out_adr(p, idx), d);
      checks++; if (d !== m_out[p][idx]) begin errors++; $display("FAIL obuf_rd S%0d[%0d] got %h exp %h", p, idx, d, m_out[p][idx]); end
    end
  endtask

  task automatic test_regs;
    logic [15:0] d;
    reg_wr(A_MAX, 16'd3);
    reg_wr(A_RUN, 16'd3);
    dma_io_rdata_in = 16'h5a5a;
    reg_rd(A_MAX, d);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL reg_max got %h exp 0003", d); end
    reg_rd(A_RUN, d);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL reg_run got %h exp 0003", d); end
    reg_rd(14'h1234, d);
    checks++; if (d !== 16'h5a5a) begin errors++; $display("FAIL reg_passthru got %h exp 5a5a", d); end
    reg_rd(14'h3FFB, d);
    checks++; if (d !== 16'h5a5a) begin errors++; $display("FAIL reg_passthru_3ffb got %h exp 5a5a", d); end
  endtask

  task automatic test_rdata_zero;
    logic [15:0] d;
    bus_wr(in_adr(0, 1), 16'hbeef);
    @(negedge clk);
    ibus_ren = 1'b0; ibus_radr = in_adr(0, 1);
    @(negedge clk);
    checks++; if (ibus_rdata !== 16'h0) begin errors++; $display("FAIL ren0 got %h exp 0000", ibus_rdata); end
    bus_rd(16'h2000, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL unmapped_2000 got %h exp 0000", d); end
    bus_rd(16'h8800, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL unmapped_8800 got %h exp 0000", d); end
  endtask

  task automatic test_spec_run;
    logic [15:0] exp_v [4];
    logic [15:0] d;
    int t0, dur;
    exp_v = '{16'd30, 16'd174, 16'd446, 16'd846};
    for (int b = 0; b < 4; b++)
      for (int idx = 0; idx < 16; idx++) bus_wr(in_adr(b, idx), 16'(idx + 1));
    prefill_out(8);
    reg_wr(A_MAX, 16'd3);
    reg_wr(A_RUN, 16'd3);
    start_run(t0);
    wait_idle(16, t0, dur);
    checks++; if (dur < 17 || dur > 24) begin errors++; $display("FAIL spec_run_time got %0d exp 17..24", dur); end
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 4; r++) begin
        bus_rd(out_adr(p, r), d);
        checks++; if (d !== exp_v[r]) begin errors++; $display("FAIL spec_run S%0d[%0d] got %0d exp %0d", p, r, d, exp_v[r]); end
      end
      for (int r = 4; r < 8; r++) begin
        bus_rd(out_adr(p, r), d);
        checks++; if (d !== m_out[p][r]) begin errors++; $display("FAIL spec_untouched S%0d[%0d] got %h exp %h", p, r, d, m_out[p][r]); end
      end
      bus_rd(out_adr(p, 256), d);
      checks++; if (d !== m_out[p][256]) begin errors++; $display("FAIL spec_untouched S%0d[256] got %h exp %h", p, d, m_out[p][256]); end
    end
  endtask

  task automatic test_distinct;
    logic [15:0] exp_v [4];
    logic [15:0] d;
    int t0, dur;
    exp_v = '{16'd20, 16'd30, 16'd28, 16'd42};
    for (int idx = 0; idx < 2; idx++) begin
      bus_wr(in_adr(0, idx), 16'd2);
      bus_wr(in_adr(1, idx), 16'd3);
      bus_wr(in_adr(2, idx), 16'd5);
      bus_wr(in_adr(3, idx), 16'd7);
    end
    prefill_out(2);
    reg_wr(A_MAX, 16'd1);
    reg_wr(A_RUN, 16'd0);
    start_run(t0);
    wait_idle(2, t0, dur);
    checks++; if (dur < 3 || dur > 10) begin errors++; $display("FAIL distinct_time got %0d exp 3..10", dur); end
    for (int p = 0; p < 4; p++) begin
      bus_rd(out_adr(p, 0), d);
      checks++; if (d !== exp_v[p]) begin errors++; $display("FAIL distinct S%0d[0] got %0d exp %0d", p, d, exp_v[p]); end
      bus_rd(out_adr(p, 1), d);
      checks++; if (d !== m_out[p][1]) begin errors++; $display("FAIL distinct_untouched S%0d[1] got %h exp %h", p, d, m_out[p][1]); end
    end
  endtask

  task automatic test_random_runs;
    logic [15:0] d;
    int mx, rn, n, t0, dur;
    for (int it = 0; it < 5; it++) begin
      mx = (it == 0) ? 0 : int'($urandom_range(0, 5));
      rn = int'($urandom_range(0, 6));
      n = (mx + 1) * (rn + 1);
      fill_inputs(n);
      prefill_out(10);
      reg_wr(A_MAX, 16'(mx));
      reg_wr(A_RUN, 16'(rn));
      model_run(mx, rn);
      start_run(t0);
      wait_idle(n, t0, dur);
      checks++; if (dur < n + 1 || dur > n + 8) begin errors++; $display("FAIL rand_time it%0d got %0d exp %0d..%0d", it, dur, n + 1, n + 8); end
      for (int p = 0; p < 4; p++)
        for (int r = 0; r < 10; r++) begin
          bus_rd(out_adr(p, r), d);
          checks++; if (d !== m_out[p][r]) begin errors++; $display("FAIL rand it%0d S%0d[%0d] got %h exp %h", it, p, r, d, m_out[p][r]); end
        end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] d;
    int idxs [8];
    int t0, dur;
    idxs = '{0, 1, 75, 76, 77, 200, 510, 511};
    fill_inputs(1024);
    prefill_out(0);
    reg_wr(A_MAX, 16'd0);
    reg_wr(A_RUN, 16'd1099);
    model_run(0, 1099);
    start_run(t0);
    wait_idle(1100, t0, dur);
    checks++; if (dur < 1101 || dur > 1108) begin errors++; $display("FAIL wrap_time got %0d exp 1101..1108", dur); end
    for (int p = 0; p < 4; p++)
      foreach (idxs[q]) begin
        bus_rd(out_adr(p, idxs[q]), d);
        checks++; if (d !== m_out[p][idxs[q]]) begin errors++; $display("FAIL wrap S%0d[%0d] got %h exp %h", p, idxs[q], d, m_out[p][idxs[q]]); end
      end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    int t0, dur;
    fill_inputs(64);
    prefill_out(9);
    reg_wr(A_MAX, 16'd7);
    reg_wr(A_RUN, 16'd7);
    model_run(7, 7);
    start_run(t0);
    repeat (10) @(negedge clk);
    reg_wr(A_START, 16'hffff);
    reg_wr(A_MAX, 16'd0);
    reg_wr(A_RUN, 16'd0);
    wait_idle(64, t0, dur);
    checks++; if (dur < 65 || dur > 72) begin errors++; $display("FAIL b2b_time got %0d exp 65..72", dur); end
    repeat (20) @(negedge clk);
    reg_rd(A_START, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL b2b_no_restart got %h exp 0000", d); end
    reg_rd(A_MAX, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL b2b_max_accepted got %h exp 0000", d); end
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 9; r++) begin
        bus_rd(out_adr(p, r), d);
        checks++; if (d !== m_out[p][r]) begin errors++; $display("FAIL b2b S%0d[%0d] got %h exp %h", p, r, d, m_out[p][r]); end
      end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] old_v [4][16];
    logic [15:0] d;
    int t0;
    fill_inputs(256);
    prefill_out(16);
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 16; r++) old_v[p][r] = m_out[p][r];
    reg_wr(A_MAX, 16'd15);
    reg_wr(A_RUN, 16'd15);
    model_run(15, 15);
    start_run(t0);
    repeat (40) @(negedge clk);
    reg_rd(A_START, d);
    checks++; if (d !== 16'h1) begin errors++; $display("FAIL midrun_busy got %h exp 0001", d); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reg_rd(A_START, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL midrun_reset_busy got %h exp 0000", d); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    reg_rd(A_START, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL after_reset_busy got %h exp 0000", d); end
    reg_rd(A_MAX, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL after_reset_max got %h exp 0000", d); end
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < 16; r++) begin
        bus_rd(out_adr(p, r), d);
        checks++;
        if (r >= 3 ? (d !== old_v[p][r]) : (d !== old_v[p][r] && d !== m_out[p][r])) begin
          errors++;
          $display("FAIL midrun S%0d[%0d] got %h exp %h (or %h)", p, r, d, old_v[p][r], m_out[p][r]);
        end
      end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc_ctr = 0;
    rst_n = 1'b0;
    dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
    dma_io_radr = '0; dma_io_rdata_in = 16'h5a5a;
    ibus_ren = 1'b0; ibus_radr = '0;
    ibus_wen = 1'b0; ibus_wadr = '0; ibus_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_ibus_rw();
    test_regs();
    test_rdata_zero();
    test_spec_run();
    test_distinct();
    test_random_runs();
    test_wrap();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
